// File: rtl/veririsc_sequencer.sv
// Eight-phase fetch/execute controller for the VeriRISC datapath, decoding opcode into strobes.
// Optional macro CTRL_RESUME_EN lets the resume input release the halted state.
module veririsc_sequencer #(
  parameter int OPC_W   = 3,
  parameter int PHASE_W = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [OPC_W-1:0]   opcode,
  input  logic               a_is_zero,
  input  logic               resume,
  output logic               sel,
  output logic               rd,
  output logic               wr,
  output logic               ld_ir,
  output logic               ld_ac,
  output logic               ld_pc,
  output logic               inc_pc,
  output logic               data_e,
  output logic               halt,
  output logic [PHASE_W-1:0] phase
);

  localparam logic [OPC_W-1:0] OP_HLT = OPC_W'(0);
  localparam logic [OPC_W-1:0] OP_SKZ = OPC_W'(1);
  localparam logic [OPC_W-1:0] OP_ADD = OPC_W'(2);
  localparam logic [OPC_W-1:0] OP_AND = OPC_W'(3);
  localparam logic [OPC_W-1:0] OP_XOR = OPC_W'(4);
  localparam logic [OPC_W-1:0] OP_LDA = OPC_W'(5);
  localparam logic [OPC_W-1:0] OP_STO = OPC_W'(6);
  localparam logic [OPC_W-1:0] OP_JMP = OPC_W'(7);

  localparam logic [PHASE_W-1:0] PH_INST_ADDR  = PHASE_W'(0);
  localparam logic [PHASE_W-1:0] PH_INST_FETCH = PHASE_W'(1);
  localparam logic [PHASE_W-1:0] PH_INST_LOAD  = PHASE_W'(2);
  localparam logic [PHASE_W-1:0] PH_IDLE       = PHASE_W'(3);
  localparam logic [PHASE_W-1:0] PH_OP_ADDR    = PHASE_W'(4);
  localparam logic [PHASE_W-1:0] PH_OP_FETCH   = PHASE_W'(5);
  localparam logic [PHASE_W-1:0] PH_ALU_OP     = PHASE_W'(6);
  localparam logic [PHASE_W-1:0] PH_STORE      = PHASE_W'(7);

  logic [PHASE_W-1:0] phase_q, phase_d;
  logic               halted_q, halted_d;
  logic               alu_op;

  assign alu_op = (opcode == OP_ADD) || (opcode == OP_AND) ||
                  (opcode == OP_XOR) || (opcode == OP_LDA);

`ifndef CTRL_RESUME_EN
  logic unused_resume;
  assign unused_resume = resume;
`endif

  always_comb begin
    phase_d  = phase_q;
    halted_d = halted_q;
    if (halted_q) begin
`ifdef CTRL_RESUME_EN
      // PC already advanced in phase 4, so rejoin the cycle after the operand phases.
      if (resume) begin
        halted_d = 1'b0;
        phase_d  = PH_OP_FETCH;
      end
`endif
    end else if (phase_q == PH_OP_ADDR && opcode == OP_HLT) begin
      halted_d = 1'b1;
    end else begin
      phase_d = phase_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q  <= PH_INST_ADDR;
      halted_q <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      halted_q <= halted_d;
    end
  end

  // Unregistered decode: strobes are valid in the same cycle as their phase.
  always_comb begin
    sel    = 1'b0;
    rd     = 1'b0;
    wr     = 1'b0;
    ld_ir  = 1'b0;
    ld_ac  = 1'b0;
    ld_pc  = 1'b0;
    inc_pc = 1'b0;
    data_e = 1'b0;
    halt   = 1'b0;
    if (halted_q) begin
      halt = 1'b1;
    end else begin
      case (phase_q)
        PH_INST_ADDR:  sel = 1'b1;
        PH_INST_FETCH: begin sel = 1'b1; rd = 1'b1; end
        PH_INST_LOAD:  begin sel = 1'b1; rd = 1'b1; ld_ir = 1'b1; end
        PH_IDLE:       begin sel = 1'b1; rd = 1'b1; ld_ir = 1'b1; end
        PH_OP_ADDR: begin
          inc_pc = 1'b1;
          halt   = (opcode == OP_HLT);
        end
        PH_OP_FETCH:   rd = alu_op;
        PH_ALU_OP: begin
          rd     = alu_op;
          inc_pc = (opcode == OP_SKZ) && a_is_zero;
          ld_pc  = (opcode == OP_JMP);
          data_e = (opcode == OP_STO);
        end
        PH_STORE: begin
          rd     = alu_op;
          ld_ac  = alu_op;
          ld_pc  = (opcode == OP_JMP);
          wr     = (opcode == OP_STO);
          data_e = (opcode == OP_STO);
        end
        default: ;
      endcase
    end
  end

  assign phase = phase_q;

endmodule

// File: tb/tb_veririsc_sequencer.sv
// Scoreboard bench for veririsc_sequencer: directed opcode sequences with hand-built strobe tables.
module tb_veririsc_sequencer;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] opcode = 3'd2;
  logic       a_is_zero = 1'b0;
  logic       resume = 1'b0;
  logic       sel, rd, wr, ld_ir, ld_ac, ld_pc, inc_pc, data_e, halt;
  logic [2:0] phase;

  int checks = 0;
  int errors = 0;
  logic [11:0] expq[$];
  string       tagq[$];
  string       cur_tag = "reset";

  veririsc_sequencer dut (
    .clk(clk), .rst(rst), .opcode(opcode), .a_is_zero(a_is_zero), .resume(resume),
    .sel(sel), .rd(rd), .wr(wr), .ld_ir(ld_ir), .ld_ac(ld_ac), .ld_pc(ld_pc),
    .inc_pc(inc_pc), .data_e(data_e), .halt(halt), .phase(phase)
  );

  always #5 clk = ~clk;

  // Expected word: {phase[2:0], sel, rd, wr, ld_ir, ld_ac, ld_pc, inc_pc, data_e, halt}
  always @(negedge clk) begin
    if (expq.size() > 0) begin
      logic [11:0] e, a;
      string t;
      e = expq.pop_front();
      t = tagq.pop_front();
      a = {phase, sel, rd, wr, ld_ir, ld_ac, ld_pc, inc_pc, data_e, halt};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL %s: got phase=%0d strobes=%09b, expected phase=%0d strobes=%09b",
                 t, a[11:9], a[8:0], e[11:9], e[8:0]);
      end
    end
  end

  task automatic push(input logic [2:0] ph, input logic [8:0] s);
    expq.push_back({ph, s});
    tagq.push_back($sformatf("%s_p%0d", cur_tag, ph));
  endtask

  task automatic step(input logic [2:0] ph, input logic [8:0] s);
    push(ph, s);
    @(posedge clk); #1;
  endtask

  task automatic run_instr(input string tag, input logic [2:0] op, input logic az,
                           input logic [0:7][8:0] tbl);
    cur_tag = tag;
    opcode = op;
    a_is_zero = az;
    for (int p = 0; p < 8; p++) step(3'(p), tbl[p]);
  endtask

  initial begin
    @(posedge clk); #1;
    step(3'd0, 9'h100);           // held in reset: only sel
    rst = 1'b0;
    run_instr("add",      3'd2, 1'b0, {9'h100, 9'h180, 9'h1A0, 9'h1A0, 9'h004, 9'h080, 9'h080, 9'h090});
    run_instr("skz_z1",   3'd1, 1'b1, {9'h100, 9'h180, 9'h1A0, 9'h1A0, 9'h004, 9'h000, 9'h004, 9'h000});
    run_instr("skz_z0",   3'd1, 1'b0, {9'h100, 9'h180, 9'h1A0, 9'h1A0, 9'h004, 9'h000, 9'h000, 9'h000});
    run_instr("sto",      3'd6, 1'b0, {9'h100, 9'h180, 9'h1A0, 9'h1A0, 9'h004, 9'h000, 9'h002, 9'h042});
    run_instr("jmp",      3'd7, 1'b1, {9'h100, 9'h180, 9'h1A0, 9'h1A0, 9'h004, 9'h000, 9'h008, 9'h008});
    run_instr("lda",      3'd5, 1'b0, {9'h100, 9'h180, 9'h1A0, 9'h1A0, 9'h004, 9'h080, 9'h080, 9'h090});

    // HLT: one inc_pc pulse in phase 4, then frozen with only halt asserted
    cur_tag = "hlt";
    opcode = 3'd0;
    step(3'd0, 9'h100); step(3'd1, 9'h180); step(3'd2, 9'h1A0); step(3'd3, 9'h1A0);
    step(3'd4, 9'h005);
    cur_tag = "halted";
    for (int i = 0; i < 22; i++) step(3'd4, 9'h001);
    cur_tag = "resume";
    resume = 1'b1;
    step(3'd4, 9'h001);
    resume = 1'b0;
`ifdef CTRL_RESUME_EN
    step(3'd5, 9'h000); step(3'd6, 9'h000); step(3'd7, 9'h000); step(3'd0, 9'h100);
`else
    for (int i = 0; i < 4; i++) step(3'd4, 9'h001);
`endif

    // Reset while halted clears halted at once
    cur_tag = "rst_halted";
    #1 rst = 1'b1;
    push(3'd0, 9'h100);
    @(posedge clk); #1;
    rst = 1'b0;

    // Async reset in the middle of phase 6 of a STO
    cur_tag = "sto_pre";
    opcode = 3'd6;
    for (int p = 0; p < 6; p++)
      step(3'(p), (p == 0) ? 9'h100 : (p == 1) ? 9'h180 : (p < 4) ? 9'h1A0 : (p == 4) ? 9'h004 : 9'h000);
    cur_tag = "rst_mid";
    #2 rst = 1'b1;
    push(3'd0, 9'h100);
    @(posedge clk); #1;
    step(3'd0, 9'h100);
    rst = 1'b0;
    run_instr("after_rst", 3'd3, 1'b0, {9'h100, 9'h180, 9'h1A0, 9'h1A0, 9'h004, 9'h080, 9'h080, 9'h090});

    @(negedge clk); #1;
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", expq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/veririsc_sequencer.md
Name: veririsc_sequencer

Overview:
- Controller stage directly upstream of the 8-bit ALU.
- Runs the 8-phase fetch/execute cycle and decodes the instruction opcode into datapath strobes (memory select/read/write, IR/AC/PC loads, PC increment, data bus enable, halt).
- Consumes the ALU's A-is-zero flag to resolve SKZ.
- Its strobes gate the ALU result into the accumulator.

Parameters:
- OPC_W, 3, opcode width; must match the ALU opcode port.
- PHASE_W, 3, phase counter width; 8 phases, fixed.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset; asynchronous, active-high.
- opcode  in  OPC_W  instruction opcode from IR; 0 HLT, 1 SKZ, 2 ADD, 3 AND, 4 XOR, 5 LDA, 6 STO, 7 JMP.
- a_is_zero  in  1  accumulator-zero flag from the ALU.
- resume  in  1  leave halted state; used only with CTRL_RESUME_EN.
- sel  out  1  1 = memory address from PC, 0 = from IR operand.
- rd  out  1  memory read.
- wr  out  1  memory write.
- ld_ir  out  1  load instruction register.
- ld_ac  out  1  load accumulator from ALU output.
- ld_pc  out  1  load PC (jump).
- inc_pc  out  1  increment PC.
- data_e  out  1  drive accumulator onto data bus.
- halt  out  1  processor halted / halting.
- phase  out  PHASE_W  current phase, for debug.

Behaviour:
- Phase register:
  - Reset (async) sets phase=0 and halted=0.
  - All outputs are 0 during reset, except sel=1, which is decoded from phase 0.
  - Each clk, phase <= phase+1, wrapping 7->0, unless halted.
- Outputs are pure decode of phase, opcode, a_is_zero and halted. There is no output register, so strobes are valid in the same cycle as the phase.
- Define ALUOP = opcode in {ADD, AND, XOR, LDA}. Per-phase strobe decode:
  - 0 INST_ADDR: sel=1.
  - 1 INST_FETCH: sel=1, rd=1.
  - 2 INST_LOAD: sel=1, rd=1, ld_ir=1.
  - 3 IDLE: sel=1, rd=1, ld_ir=1.
  - 4 OP_ADDR: inc_pc=1; halt=1 if opcode==HLT.
  - 5 OP_FETCH: rd=ALUOP.
  - 6 ALU_OP: rd=ALUOP; inc_pc=(opcode==SKZ && a_is_zero); ld_pc=(opcode==JMP); data_e=(opcode==STO).
  - 7 STORE: rd=ALUOP; ld_ac=ALUOP; ld_pc=(opcode==JMP); wr=(opcode==STO); data_e=(opcode==STO).
- Halt:
  - In phase 4 with opcode==HLT, halted is set at the clock edge and phase stays at 4.
  - While halted: halt=1, phase frozen at 4, every other strobe 0 (inc_pc is also 0).
  - Net effect: inc_pc pulses exactly once for a HLT instruction.
- opcode is sampled combinationally; it must be stable from phase 3 onward, because IR loads in phases 2 and 3.
- a_is_zero is sampled combinationally in phase 6 only.
- rst asserted mid-cycle, in any phase or while halted, immediately forces phase=0 and halted=0. The first fetch starts on the first clk after rst deasserts.
- Strobes are mutually consistent: wr=1 implies data_e=1, and wr and rd are never both 1.

Optional Feature:
- Macro CTRL_RESUME_EN.
- Defined:
  - While halted, resume=1 at a clk edge clears halted and sets phase=5.
  - Execution continues with the next instruction fetch after one idle phase group; PC was already incremented in phase 4.
  - resume is ignored when not halted.
- Not defined: the resume port exists but is ignored; only rst leaves the halted state.

Test Plan:
- Reset release, opcode=ADD(2), a_is_zero=0 -> phase counts 0..7..0. ld_ir=1 in phases 2 and 3; rd=1 in phases 1,2,3,5,6,7; ld_ac=1 only in phase 7; wr never 1.
- opcode=SKZ(1), a_is_zero=1 -> inc_pc=1 in phases 4 and 6. Repeat with a_is_zero=0 -> inc_pc=1 in phase 4 only; ld_ac stays 0.
- opcode=STO(6) -> data_e=1 in phases 6 and 7; wr=1 in phase 7 only; rd=0 in phases 5-7.
- opcode=JMP(7) -> ld_pc=1 in phases 6 and 7; inc_pc=1 in phase 4; ld_ac=0.
- opcode=HLT(0) -> halt=1 from phase 4 onward. phase stays 4 for 20+ cycles; inc_pc pulses exactly once, all other strobes 0. With CTRL_RESUME_EN, resume=1 for one cycle -> next cycle phase=5, halt=0, then the sequence continues 6,7,0.
- rst pulsed asynchronously mid-phase 6, between clock edges -> phase=0 and sel=1 immediately, all other strobes 0. After release, the fetch restarts from phase 0.
